// File: rtl/stage_cfg_pkg.sv
// stage_cfg_pkg: header layout, config type codes and beat counts shared by the stage configurator
package stage_cfg_pkg;
  localparam int HDR_ID_LSB   = 12;
  localparam int HDR_TYPE_LSB = 8;
  localparam int HDR_FLD_W    = 4;
  localparam logic [3:0] CFG_KEYOFF = 4'd0;
  localparam logic [3:0] CFG_CAM    = 4'd1;
  localparam logic [3:0] CFG_ACT    = 4'd2;
  localparam int BEATS_KEYOFF = 1;
  localparam int BEATS_CAM    = 2;
  localparam int ACT_ALUS     = 25;
  typedef enum logic [1:0] {S_IDLE, S_FWD, S_LOAD} state_t;
  function automatic int act_beats(input int act_w, input int dw);
    return (act_w + dw - 1) / dw;
  endfunction
endpackage

// File: rtl/stage_cfg_axis_fwd.sv
// stage_cfg_axis_fwd: one-cycle AXI-Stream register slice; payload is zeroed whenever the beat is not forwarded
module stage_cfg_axis_fwd #(
  parameter int DW = 256,
  parameter int UW = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [DW-1:0]   i_tdata,
  input  logic [UW-1:0]   i_tuser,
  input  logic [DW/8-1:0] i_tkeep,
  input  logic            i_tlast,
  output logic [DW-1:0]   o_tdata,
  output logic [UW-1:0]   o_tuser,
  output logic [DW/8-1:0] o_tkeep,
  output logic            o_tvalid,
  output logic            o_tlast
);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tdata  <= '0;
      o_tuser  <= '0;
      o_tkeep  <= '0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
    end else begin
      o_tdata  <= i_en ? i_tdata : '0;
      o_tuser  <= i_en ? i_tuser : '0;
      o_tkeep  <= i_en ? i_tkeep : '0;
      o_tvalid <= i_en;
      o_tlast  <= i_en & i_tlast;
    end
  end
endmodule

// File: rtl/stage_cfg_ctrl.sv
// stage_cfg_ctrl: consumes control packets for this stage into table write strobes, forwards the rest
module stage_cfg_ctrl
  import stage_cfg_pkg::*;
#(
  parameter int STAGE_ID             = 0,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int KEY_OFF              = 18,
  parameter int KEY_LEN              = 197,
  parameter int ACT_LEN              = 25,
  parameter int ADDR_WIDTH           = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic [KEY_OFF-1:0]                key_off_entry_out,
  output logic [ADDR_WIDTH-1:0]             key_off_entry_addr,
  output logic                              key_off_entry_valid,
  output logic [KEY_LEN-1:0]                lookup_din,
  output logic [KEY_LEN-1:0]                lookup_din_mask,
  output logic [ADDR_WIDTH-1:0]             lookup_din_addr,
  output logic                              lookup_din_en,
  output logic [ACT_LEN*ACT_ALUS-1:0]       action_data_out,
  output logic [ADDR_WIDTH-1:0]             action_addr,
  output logic                              action_en,
  output logic [15:0]                       cfg_wr_cnt,
  output logic [15:0]                       cfg_err_cnt
);
  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int ACT_W = ACT_LEN * ACT_ALUS;
  localparam int NB    = act_beats(ACT_W, DW);
  localparam int ACC_W = NB * DW;
  state_t r_state, w_next;
  logic [3:0] r_type, r_cnt, w_need, w_cnt_nx;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ACC_W-1:0] r_acc, w_acc;
  logic [3:0] w_hdr_id, w_hdr_type;
  logic w_own, w_hdr, w_take, w_load, w_done, w_err, w_fwd, w_unused_acc;
  assign w_hdr_id     = c_s_axis_tdata[HDR_ID_LSB +: HDR_FLD_W];
  assign w_hdr_type   = c_s_axis_tdata[HDR_TYPE_LSB +: HDR_FLD_W];
  assign w_own        = w_hdr_id == 4'(STAGE_ID) && w_hdr_type <= CFG_ACT;
  assign w_need       = r_type == CFG_KEYOFF ? 4'(BEATS_KEYOFF) : r_type == CFG_CAM ? 4'(BEATS_CAM) : 4'(NB);
  assign w_take       = r_cnt < w_need;
  assign w_cnt_nx     = r_cnt + 4'(w_take);
  assign w_unused_acc = ^w_acc[ACC_W-1:ACT_W];
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = !c_s_axis_tvalid ? r_state :
             c_s_axis_tlast   ? S_IDLE :
             r_state == S_IDLE ? (w_own ? S_LOAD : S_FWD) : r_state;
  end
  always_comb begin
    w_hdr  = r_state == S_IDLE && c_s_axis_tvalid && w_own;
    w_load = r_state == S_LOAD && c_s_axis_tvalid;
    w_done = w_load && c_s_axis_tlast && w_cnt_nx >= w_need;
    w_err  = c_s_axis_tlast && ((w_hdr) || (w_load && w_cnt_nx < w_need));
    w_fwd  = c_s_axis_tvalid && (r_state == S_FWD || (r_state == S_IDLE && !w_own));
  end
  // Each payload beat lands in its own slot, so a later packet never sees an earlier packet's beats
  always_comb begin
    w_acc = r_acc;
    for (int b = 0; b < NB; b++)
      if (w_take && r_cnt == 4'(b)) w_acc[b*DW +: DW] = c_s_axis_tdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_type              <= '0;
      r_idx               <= '0;
      r_cnt               <= '0;
      r_acc               <= '0;
      key_off_entry_out   <= '0;
      key_off_entry_addr  <= '0;
      key_off_entry_valid <= 1'b0;
      lookup_din          <= '0;
      lookup_din_mask     <= '0;
      lookup_din_addr     <= '0;
      lookup_din_en       <= 1'b0;
      action_data_out     <= '0;
      action_addr         <= '0;
      action_en           <= 1'b0;
      cfg_wr_cnt          <= '0;
      cfg_err_cnt         <= '0;
    end else begin
      key_off_entry_valid <= w_done && r_type == CFG_KEYOFF;
      lookup_din_en       <= w_done && r_type == CFG_CAM;
      action_en           <= w_done && r_type == CFG_ACT;
      if (w_hdr) begin
        r_type <= w_hdr_type;
        r_idx  <= c_s_axis_tdata[ADDR_WIDTH-1:0];
        r_cnt  <= '0;
      end
      if (w_load) begin
        r_acc <= w_acc;
        r_cnt <= w_cnt_nx;
      end
      if (w_done && r_type == CFG_KEYOFF) begin
        key_off_entry_out  <= w_acc[KEY_OFF-1:0];
        key_off_entry_addr <= r_idx;
      end
      if (w_done && r_type == CFG_CAM) begin
        lookup_din      <= w_acc[KEY_LEN-1:0];
        lookup_din_mask <= w_acc[DW +: KEY_LEN];
        lookup_din_addr <= r_idx;
      end
      if (w_done && r_type == CFG_ACT) begin
        action_data_out <= w_acc[ACT_W-1:0];
        action_addr     <= r_idx;
      end
      if (w_done && ~&cfg_wr_cnt) cfg_wr_cnt <= cfg_wr_cnt + 16'd1;
      if (w_err && ~&cfg_err_cnt) cfg_err_cnt <= cfg_err_cnt + 16'd1;
    end
  end
  stage_cfg_axis_fwd #(.DW(DW), .UW(C_S_AXIS_TUSER_WIDTH)) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_fwd),
    .i_tdata  (c_s_axis_tdata),
    .i_tuser  (c_s_axis_tuser),
    .i_tkeep  (c_s_axis_tkeep),
    .i_tlast  (c_s_axis_tlast),
    .o_tdata  (c_m_axis_tdata),
    .o_tuser  (c_m_axis_tuser),
    .o_tkeep  (c_m_axis_tkeep),
    .o_tvalid (c_m_axis_tvalid),
    .o_tlast  (c_m_axis_tlast)
  );
endmodule

// File: tb/tb_stage_cfg_ctrl.sv
// tb_stage_cfg_ctrl: vector table, hand sequences and random packets against a packet-level reference model
module tb_stage_cfg_ctrl;
  localparam int DW = 256, UW = 128, KW = 32, KO = 18, KL = 197, AW = 4, ACTW = 625, SID = 0;
  logic clk = 1'b0, rst;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [UW-1:0] s_tuser, m_tuser;
  logic [KW-1:0] s_tkeep, m_tkeep;
  logic s_tvalid, s_tlast, m_tvalid, m_tlast;
  logic [KO-1:0] ko_d;
  logic [AW-1:0] ko_a, lk_a, ac_a;
  logic ko_v, lk_en, ac_en;
  logic [KL-1:0] lk_d, lk_m;
  logic [ACTW-1:0] ac_d;
  logic [15:0] wr_cnt, err_cnt;
  int errors = 0, checks = 0;

  stage_cfg_ctrl #(.STAGE_ID(SID)) dut (
    .clk(clk), .rst(rst),
    .c_s_axis_tdata(s_tdata), .c_s_axis_tuser(s_tuser), .c_s_axis_tkeep(s_tkeep),
    .c_s_axis_tvalid(s_tvalid), .c_s_axis_tlast(s_tlast),
    .c_m_axis_tdata(m_tdata), .c_m_axis_tuser(m_tuser), .c_m_axis_tkeep(m_tkeep),
    .c_m_axis_tvalid(m_tvalid), .c_m_axis_tlast(m_tlast),
    .key_off_entry_out(ko_d), .key_off_entry_addr(ko_a), .key_off_entry_valid(ko_v),
    .lookup_din(lk_d), .lookup_din_mask(lk_m), .lookup_din_addr(lk_a), .lookup_din_en(lk_en),
    .action_data_out(ac_d), .action_addr(ac_a), .action_en(ac_en),
    .cfg_wr_cnt(wr_cnt), .cfg_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: tracks whole packets, decides their fate when tlast arrives
  bit m_active, m_foreign;
  int m_type;
  logic [AW-1:0] m_idx;
  logic [DW-1:0] m_beats[$];
  logic e_mv, e_ml, e_kv, e_le, e_ae;
  logic [DW-1:0] e_md;
  logic [UW-1:0] e_mu;
  logic [KW-1:0] e_mk;
  logic [KO-1:0] e_kd;
  logic [AW-1:0] e_ka, e_la, e_aa;
  logic [KL-1:0] e_ld, e_lm;
  logic [ACTW-1:0] e_ad;
  logic [15:0] e_wr, e_err;

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return x == 16'hFFFF ? x : x + 16'd1;
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_active = 0; m_foreign = 0; m_type = 0; m_idx = '0; m_beats.delete();
    {e_mv, e_ml, e_kv, e_le, e_ae} = '0;
    e_md = '0; e_mu = '0; e_mk = '0; e_kd = '0; e_ka = '0; e_la = '0; e_aa = '0;
    e_ld = '0; e_lm = '0; e_ad = '0; e_wr = '0; e_err = '0;
  endtask

  task automatic model_step();
    int id, ty, need;
    logic [3*DW-1:0] cat;
    {e_mv, e_ml, e_kv, e_le, e_ae} = '0;
    e_md = '0; e_mu = '0; e_mk = '0;
    if (!s_tvalid) return;
    if (!m_active) begin
      id = int'(s_tdata[15:12]);
      ty = int'(s_tdata[11:8]);
      if (id == SID && ty < 3) begin
        if (s_tlast) e_err = sat_inc(e_err);
        else begin
          m_active = 1; m_foreign = 0; m_type = ty; m_idx = s_tdata[AW-1:0]; m_beats.delete();
        end
      end else begin
        e_mv = 1; e_md = s_tdata; e_mu = s_tuser; e_mk = s_tkeep; e_ml = s_tlast;
        if (!s_tlast) begin m_active = 1; m_foreign = 1; end
      end
    end else if (m_foreign) begin
      e_mv = 1; e_md = s_tdata; e_mu = s_tuser; e_mk = s_tkeep; e_ml = s_tlast;
      if (s_tlast) m_active = 0;
    end else begin
      m_beats.push_back(s_tdata);
      if (s_tlast) begin
        m_active = 0;
        need = m_type == 0 ? 1 : m_type == 1 ? 2 : 3;
        if (m_beats.size() >= need) begin
          cat = '0;
          for (int i = 0; i < need; i++) cat[i*DW +: DW] = m_beats[i];
          e_wr = sat_inc(e_wr);
          if (m_type == 0) begin e_kv = 1; e_kd = cat[KO-1:0]; e_ka = m_idx; end
          if (m_type == 1) begin e_le = 1; e_ld = cat[KL-1:0]; e_lm = cat[DW +: KL]; e_la = m_idx; end
          if (m_type == 2) begin e_ae = 1; e_ad = cat[ACTW-1:0]; e_aa = m_idx; end
        end else e_err = sat_inc(e_err);
      end
    end
  endtask

  task automatic chk(input string n, input logic [639:0] a, input logic [639:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic compare_all();
    chk("m_tvalid", m_tvalid, e_mv); chk("m_tdata", m_tdata, e_md); chk("m_tuser", m_tuser, e_mu);
    chk("m_tkeep", m_tkeep, e_mk); chk("m_tlast", m_tlast, e_ml);
    chk("ko_valid", ko_v, e_kv); chk("ko_data", ko_d, e_kd); chk("ko_addr", ko_a, e_ka);
    chk("cam_en", lk_en, e_le); chk("cam_key", lk_d, e_ld); chk("cam_mask", lk_m, e_lm); chk("cam_addr", lk_a, e_la);
    chk("act_en", ac_en, e_ae); chk("act_data", ac_d, e_ad); chk("act_addr", ac_a, e_aa);
    chk("wr_cnt", wr_cnt, e_wr); chk("err_cnt", err_cnt, e_err);
  endtask

  task automatic step(input logic r, input logic v, input logic l, input logic [DW-1:0] d);
    rst = r; s_tvalid = v; s_tlast = l; s_tdata = d;
    s_tuser = {$urandom, $urandom, $urandom, $urandom}; s_tkeep = $urandom;
    if (r) model_reset(); else model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic v, l;
    logic [DW-1:0] d;
    logic ko, cam, act, mv;
    logic [15:0] wr, err;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic v, l, input logic [DW-1:0] d,
                              input logic ko, cam, act, mv, input logic [15:0] wr, err);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.ko = ko; t.cam = cam; t.act = act; t.mv = mv; t.wr = wr; t.err = err;
    return t;
  endfunction

  initial begin
    logic [DW-1:0] a, b, c, ones;
    a = {8{32'hA0A1A2A3}}; b = {8{32'hB0B1B2B3}}; c = {8{32'hC0C1C2C3}}; ones = '1;
    tbl.push_back(mk(1, 0, 'h0003,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 'h2A5A5, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 'h0107,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 'h1234,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 'hDEAD,  0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, ones,    0, 1, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 'h020F,  0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, a,       0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, b,       0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 1, c,       0, 0, 1, 0, 3, 0));
    tbl.push_back(mk(1, 0, 'h2000,  0, 0, 0, 1, 3, 0));
    tbl.push_back(mk(1, 0, 'h11,    0, 0, 0, 1, 3, 0));
    tbl.push_back(mk(1, 0, 'h22,    0, 0, 0, 1, 3, 0));
    tbl.push_back(mk(1, 1, 'h33,    0, 0, 0, 1, 3, 0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 'h0201,  0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 0, 'h44,    0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(1, 1, 'h45,    0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(1, 0, 'h0005,  0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(1, 1, 'h15555, 1, 0, 0, 0, 4, 1));
    tbl.push_back(mk(1, 1, 'h0000,  0, 0, 0, 0, 4, 2));
    tbl.push_back(mk(1, 1, 'h0300,  0, 0, 0, 1, 4, 2));
    tbl.push_back(mk(1, 0, 'h0100,  0, 0, 0, 0, 4, 2));
    tbl.push_back(mk(1, 0, 'h55,    0, 0, 0, 0, 4, 2));
    tbl.push_back(mk(1, 0, 'h66,    0, 0, 0, 0, 4, 2));
    tbl.push_back(mk(1, 1, 'h77,    0, 1, 0, 0, 5, 2));

    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].v, tbl[i].l, tbl[i].d);
      chk($sformatf("tbl%0d_ko", i), ko_v, tbl[i].ko);
      chk($sformatf("tbl%0d_cam", i), lk_en, tbl[i].cam);
      chk($sformatf("tbl%0d_act", i), ac_en, tbl[i].act);
      chk($sformatf("tbl%0d_mv", i), m_tvalid, tbl[i].mv);
      chk($sformatf("tbl%0d_wr", i), wr_cnt, tbl[i].wr);
      chk($sformatf("tbl%0d_err", i), err_cnt, tbl[i].err);
      if (i == 1) begin chk("ko_plan_addr", ko_a, 4'd3); chk("ko_plan_data", ko_d, 18'h2A5A5); end
      if (i == 5) begin chk("cam_plan_key", lk_d, 197'h1234); chk("cam_plan_addr", lk_a, 4'd7); end
      if (i == 9) begin chk("act_plan_data", ac_d, {c[112:0], b, a}); chk("act_plan_addr", ac_a, 4'hF); end
    end

    // Reset in the middle of a CAM packet, then a clean key_off write
    step(0, 1, 0, 'h0109);
    step(0, 1, 0, 'hBAD0BAD);
    step(1, 0, 0, '0);
    chk("rst_wr_cnt", wr_cnt, 16'd0);
    chk("rst_cam_key", lk_d, '0);
    step(0, 1, 0, 'h0002);
    step(0, 1, 1, 'h3C3C3);
    chk("post_rst_ko", ko_v, 1'b1);
    chk("post_rst_ko_data", ko_d, 18'h3C3C3);
    chk("post_rst_no_cam", lk_en, 1'b0);
    step(0, 0, 0, '0);

    for (int p = 0; p < 300; p++) begin
      logic [DW-1:0] h;
      int len;
      h = rnd_beat();
      h[15:12] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'(SID);
      h[11:8] = 4'($urandom_range(0, 3));
      len = $urandom_range(0, 4);
      repeat ($urandom_range(0, 2)) step(0, 0, 1'($urandom), rnd_beat());
      step(0, 1, len == 0, h);
      for (int k = 1; k <= len; k++) begin
        if ($urandom_range(0, 3) == 0) step(0, 0, 1'($urandom), rnd_beat());
        step(0, 1, k == len, rnd_beat());
      end
    end
    step(0, 0, 0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_cfg_ctrl.md
Name: stage_cfg_ctrl

Overview:
- Control-path configurator for one RMT pipeline stage.
- Receives control packets on the stage's control AXI-Stream (no tready; always accepts).
- Packets addressed to this stage are consumed and turned into single-cycle write strobes for the key-extractor offset RAM, the lookup CAM (key and mask) and the action RAM.
- All other packets are forwarded unchanged to the next stage's control input with one cycle of latency.

Parameters:
- STAGE_ID, 0: stage index matched against the header; valid 0-4.
- C_S_AXIS_DATA_WIDTH, 256: control tdata width.
- C_S_AXIS_TUSER_WIDTH, 128: control tuser width.
- KEY_OFF, 18: key-offset entry width.
- KEY_LEN, 197: CAM key/mask width.
- ACT_LEN, 25: single ALU action width; full action entry is ACT_LEN*25 = 625 bits.
- ADDR_WIDTH, 4: entry index width for all three tables.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- c_s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  control data in.
- c_s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  control user in.
- c_s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  control keep in.
- c_s_axis_tvalid  in  1  beat valid.
- c_s_axis_tlast  in  1  last beat of packet.
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  same widths  forwarded control stream.
- key_off_entry_out  out  KEY_OFF  offset RAM write data.
- key_off_entry_addr  out  ADDR_WIDTH  offset RAM address.
- key_off_entry_valid  out  1  offset RAM write strobe.
- lookup_din  out  KEY_LEN  CAM key.
- lookup_din_mask  out  KEY_LEN  CAM mask.
- lookup_din_addr  out  ADDR_WIDTH  CAM address.
- lookup_din_en  out  1  CAM write strobe.
- action_data_out  out  ACT_LEN*25  action entry.
- action_addr  out  ADDR_WIDTH  action address.
- action_en  out  1  action write strobe.
- cfg_wr_cnt  out  16  completed writes, saturating.
- cfg_err_cnt  out  16  dropped malformed packets, saturating.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset applied mid-packet abandons it with no write issued; the upstream control source is reset together with this block.
- Header, first beat of each packet:
  - tdata[15:12] = stage id.
  - tdata[11:8] = type: 0 = key_off, 1 = CAM, 2 = action, other = foreign.
  - tdata[ADDR_WIDTH-1:0] = index.
- Payload beats, with the lsb of each field at tdata[0]:
  - key_off: 1 beat; data = tdata[KEY_OFF-1:0].
  - CAM: 2 beats; beat1 = key, beat2 = mask.
  - action: ceil(625/DW) = 3 beats, little-endian (beat1 holds bits 255:0, beat3 holds bits 624:512; excess bits ignored).
- FSM states:
  - IDLE: on a valid header with id == STAGE_ID and type 0-2, latch type and index, clear beat_cnt, go to LOAD. Otherwise go to FWD. If tlast is on the header beat: own-stage header counts as an error (cfg_err_cnt++) and stays in IDLE; foreign header is forwarded and stays in IDLE.
  - FWD: forward beats; return to IDLE on the tlast beat.
  - LOAD: shift each valid beat into the accumulator and increment beat_cnt. Extra beats beyond the required count are ignored.
    - tlast with beat_cnt reaching the required count: issue the write and go to IDLE.
    - tlast before the required count: cfg_err_cnt++, no write, go to IDLE.
- Forward path:
  - Registered: c_m_* = c_s_* delayed exactly 1 cycle for FWD beats and for foreign header beats.
  - Consumed beats output tvalid = 0. Forwarded data/tuser/tkeep/tlast are also 0 when not valid.
- Write strobes:
  - Exactly one cycle high, in the cycle after the tlast beat is accepted; data and address are stable in that cycle and held until the next write.
  - Only the strobe matching the latched type fires. cfg_wr_cnt increments in the same cycle.
  - A new header arriving in the strobe cycle is processed normally (back-to-back packets, zero gap).
- Counters saturate at 16'hFFFF.
- tvalid low beats are ignored in every state; state and counters hold.

Decomposition:
- Shared package stage_cfg_pkg:
  - Header field offsets.
  - Type codes CFG_KEYOFF = 0, CFG_CAM = 1, CFG_ACT = 2.
  - Beat-count constants.
- Natural sub-module: stage_cfg_axis_fwd (1-cycle register slice with valid gating). The FSM, accumulator and strobes live in the top.

Test Plan:
- Key-offset write: STAGE_ID = 0; header id 0, type 0, index 3; beat1 tdata[17:0] = 18'h2A5A5 with tlast -> next cycle key_off_entry_valid = 1, addr = 3, data = 18'h2A5A5, cfg_wr_cnt = 1, c_m_axis_tvalid stays 0.
- CAM write: header type 1, index 7; key = 197'h1234, mask = all-ones -> lookup_din_en pulses once with addr = 7, the matching key/mask, no other strobe.
- Action write: header type 2, index 15; beats = A, B, C -> action_data_out = {C[112:0], B, A}, action_en one cycle.
- Foreign packet: header id 2 on a STAGE_ID 0 block, 4 beats -> identical 4 beats on c_m_axis each 1 cycle later, no strobes, counters unchanged.
- Malformed packet: action header then tlast on beat2 -> no action_en, cfg_err_cnt = 1. Next well-formed key_off packet back-to-back writes correctly.
- Reset mid-CAM-packet after beat1 -> all outputs 0; next header is parsed correctly and no stale key is written.
